// File: rtl/fp_int_converter_pipe.sv
// Integer <-> IEEE-754 binary32 converter with iterative normalisation and
// valid/ready handshakes on both sides; one operation in flight at a time.
module fp_int_converter_pipe #(
    parameter int INT_W      = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             option,
    input  logic             integer_is_signed,
    input  logic [2:0]       rm,
    input  logic [INT_W-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out,
    output logic             NV,
    output logic             NX
);

    localparam int              XW       = INT_W + 26;
    localparam logic [7:0]      EXP_INIT = 8'(127 + INT_W - 1);
    localparam logic [8:0]      HUGE_EXP = 9'(127 + INT_W);
    localparam logic [INT_W-1:0] MAX_POS  = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MIN_NEG  = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] ALL_ONES = {INT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NORM  = 3'd1,
        ST_ROUND = 3'd2,
        ST_CVT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [INT_W-1:0]   out_r;
    logic               nv_r;
    logic               nx_r;
    logic               sign_r;
    logic               is_signed_r;
    logic [2:0]         rm_r;
    logic [INT_W-1:0]   mag_r;
    logic [7:0]         exp_r;
    logic [31:0]        fp_r;

    logic               cap_sign_s;
    logic [INT_W-1:0]   cap_mag_s;
    logic               top_zero_s;

    logic [23:0]        mant_s;
    logic               rnd_g_s;
    logic               rnd_r_s;
    logic               rnd_s_s;
    logic               rnd_nx_s;
    logic [24:0]        mant_sum_s;
    logic [31:0]        fp_res_s;
    logic [INT_W-1:0]   i2f_out_s;

    logic [7:0]         f_exp_s;
    logic [7:0]         f_eff_s;
    logic [23:0]        sig_s;
    logic               huge_s;
    logic               tiny_s;
    logic [7:0]         shamt_s;
    logic [XW-1:0]      xfix_s;
    logic [INT_W-1:0]   int_part_s;
    logic               cvt_g_s;
    logic               cvt_r_s;
    logic               cvt_s_s;
    logic               cvt_nx_s;
    logic [INT_W:0]     rmag_s;
    logic [INT_W-1:0]   cvt_out_s;
    logic               cvt_nv_flag_s;
    logic               cvt_nx_flag_s;

    // Rounding increment decision; unused encodings truncate toward zero.
    function automatic logic round_inc(input logic [2:0] mode, input logic neg,
                                       input logic g, input logic r,
                                       input logic s, input logic lsb);
        logic inexact;
        inexact = g | r | s;
        case (mode)
            3'b000:  round_inc = g & (r | s | lsb);
            3'b001:  round_inc = 1'b0;
            3'b010:  round_inc = inexact & neg;
            3'b011:  round_inc = inexact & ~neg;
            3'b100:  round_inc = g;
            default: round_inc = 1'b0;
        endcase
    endfunction

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign NV        = nv_r;
    assign NX        = nx_r;

    // Sign/magnitude split of the integer operand at accept time.
    always_comb begin
        cap_sign_s = integer_is_signed & in[INT_W-1];
        if (cap_sign_s) begin
            cap_mag_s = -in;
        end else begin
            cap_mag_s = in;
        end
        top_zero_s = (mag_r[INT_W-1 -: SHIFT_STEP] == {SHIFT_STEP{1'b0}});
    end

    // Round the normalised magnitude to a binary32 word.
    always_comb begin
        mant_s     = mag_r[INT_W-1 -: 24];
        rnd_g_s    = mag_r[INT_W-25];
        rnd_r_s    = mag_r[INT_W-26];
        rnd_s_s    = |mag_r[INT_W-27:0];
        rnd_nx_s   = rnd_g_s | rnd_r_s | rnd_s_s;
        mant_sum_s = {1'b0, mant_s} +
                     {24'd0, round_inc(rm_r, sign_r, rnd_g_s, rnd_r_s, rnd_s_s, mant_s[0])};
        fp_res_s   = 32'd0;
        if (mag_r != {INT_W{1'b0}}) begin
            // Hidden bit (and any carry-out) ripples into the exponent field.
            fp_res_s[31]   = sign_r;
            fp_res_s[30:0] = {exp_r - 8'd1, 23'd0} + {6'd0, mant_sum_s};
        end else begin
            fp_res_s = 32'd0;
        end
        i2f_out_s       = {INT_W{1'b0}};
        i2f_out_s[31:0] = fp_res_s;
    end

    // Float to integer: align the significand, round, then range-check.
    always_comb begin
        f_exp_s = fp_r[30:23];
        if (f_exp_s == 8'd0) begin
            f_eff_s = 8'd1;
        end else begin
            f_eff_s = f_exp_s;
        end
        sig_s   = {(f_exp_s != 8'd0), fp_r[22:0]};
        huge_s  = ({1'b0, f_eff_s} >= HUGE_EXP);
        tiny_s  = (f_eff_s < 8'd124);
        shamt_s = f_eff_s - 8'd124;
        xfix_s  = {XW{1'b0}};
        if (!tiny_s && !huge_s) begin
            // Binary point sits between bit 26 (units) and bit 25 (guard).
            xfix_s = {{(INT_W+2){1'b0}}, sig_s} << shamt_s;
        end else begin
            xfix_s = {XW{1'b0}};
        end
        int_part_s = xfix_s[XW-1:26];
        cvt_g_s    = xfix_s[25];
        cvt_r_s    = xfix_s[24];
        cvt_s_s    = tiny_s | (|xfix_s[23:0]);
        cvt_nx_s   = cvt_g_s | cvt_r_s | cvt_s_s;
        rmag_s     = {1'b0, int_part_s} +
                     {{INT_W{1'b0}}, round_inc(rm_r, fp_r[31], cvt_g_s, cvt_r_s, cvt_s_s, int_part_s[0])};

        cvt_out_s     = {INT_W{1'b0}};
        cvt_nv_flag_s = 1'b0;
        cvt_nx_flag_s = 1'b0;
        if (f_exp_s == 8'hFF) begin
            cvt_nv_flag_s = 1'b1;
            if ((fp_r[22:0] != 23'd0) || !fp_r[31]) begin
                cvt_out_s = is_signed_r ? MAX_POS : ALL_ONES;
            end else begin
                cvt_out_s = is_signed_r ? MIN_NEG : {INT_W{1'b0}};
            end
        end else if (fp_r[30:0] == 31'd0) begin
            cvt_out_s = {INT_W{1'b0}};
        end else if (fp_r[31] && !is_signed_r) begin
            if (!huge_s && (rmag_s == {(INT_W+1){1'b0}})) begin
                cvt_nx_flag_s = cvt_nx_s;
            end else begin
                cvt_nv_flag_s = 1'b1;
            end
        end else if (fp_r[31]) begin
            if (huge_s || (rmag_s > {1'b0, MIN_NEG})) begin
                cvt_out_s     = MIN_NEG;
                cvt_nv_flag_s = 1'b1;
            end else begin
                cvt_out_s     = -rmag_s[INT_W-1:0];
                cvt_nx_flag_s = cvt_nx_s;
            end
        end else if (is_signed_r) begin
            if (huge_s || (rmag_s > {1'b0, MAX_POS})) begin
                cvt_out_s     = MAX_POS;
                cvt_nv_flag_s = 1'b1;
            end else begin
                cvt_out_s     = rmag_s[INT_W-1:0];
                cvt_nx_flag_s = cvt_nx_s;
            end
        end else begin
            if (huge_s || rmag_s[INT_W]) begin
                cvt_out_s     = ALL_ONES;
                cvt_nv_flag_s = 1'b1;
            end else begin
                cvt_out_s     = rmag_s[INT_W-1:0];
                cvt_nx_flag_s = cvt_nx_s;
            end
        end
    end

    // Control FSM with operand capture and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_r       <= {INT_W{1'b0}};
            nv_r        <= 1'b0;
            nx_r        <= 1'b0;
            sign_r      <= 1'b0;
            is_signed_r <= 1'b0;
            rm_r        <= 3'd0;
            mag_r       <= {INT_W{1'b0}};
            exp_r       <= 8'd0;
            fp_r        <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_r  <= 1'b0;
                        sign_r      <= cap_sign_s;
                        is_signed_r <= integer_is_signed;
                        rm_r        <= rm;
                        mag_r       <= cap_mag_s;
                        exp_r       <= EXP_INIT;
                        fp_r        <= in[31:0];
                        state_r     <= option ? ST_CVT : ST_NORM;
                    end
                end
                ST_NORM: begin
                    if ((mag_r == {INT_W{1'b0}}) || mag_r[INT_W-1]) begin
                        state_r <= ST_ROUND;
                    end else if (top_zero_s) begin
                        mag_r <= mag_r << SHIFT_STEP;
                        exp_r <= exp_r - 8'(SHIFT_STEP);
                    end else begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                ST_ROUND: begin
                    out_r       <= i2f_out_s;
                    nv_r        <= 1'b0;
                    nx_r        <= rnd_nx_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_CVT: begin
                    out_r       <= cvt_out_s;
                    nv_r        <= cvt_nv_flag_s;
                    nx_r        <= cvt_nx_flag_s;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_int_converter_pipe.sv
// Self-checking bench for fp_int_converter_pipe: directed plan cases plus random
// operations on a 32-bit and a 64-bit instance against an arithmetic reference.
module tb_fp_int_converter_pipe;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_option, a_sgn, a_out_valid, a_out_ready, a_nv, a_nx;
    logic [2:0]  a_rm;
    logic [31:0] a_in, a_out;

    logic        b_in_valid, b_in_ready, b_option, b_sgn, b_out_valid, b_out_ready, b_nv, b_nx;
    logic [2:0]  b_rm;
    logic [63:0] b_in, b_out;

    int          checks;
    int          errors;
    logic [63:0] last_out;

    fp_int_converter_pipe #(.INT_W(32), .SHIFT_STEP(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .option(a_option), .integer_is_signed(a_sgn), .rm(a_rm), .in(a_in),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out), .NV(a_nv), .NX(a_nx)
    );

    fp_int_converter_pipe #(.INT_W(64), .SHIFT_STEP(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .option(b_option), .integer_is_signed(b_sgn), .rm(b_rm), .in(b_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out), .NV(b_nv), .NX(b_nx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: integer to binary32 by locating the MSB and comparing the
    // discarded remainder against one half.
    function automatic logic [31:0] ref_i2f(input logic [63:0] v, input int w, input bit sg,
                                            input logic [2:0] r, output bit nx);
        logic [63:0] mask, m, q, rem, half;
        bit neg, inc;
        int p, sh;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        neg  = sg && v[w-1];
        m    = neg ? ((~v + 64'd1) & mask) : (v & mask);
        nx   = 1'b0;
        if (m == 64'd0) return 32'd0;
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        if (p <= 23) begin
            q = m << (23 - p); rem = 64'd0; half = 64'd1;
        end else begin
            sh = p - 23;
            q = m >> sh; rem = m & ((64'd1 << sh) - 64'd1); half = 64'd1 << (sh - 1);
        end
        nx = (rem != 64'd0);
        case (r)
            3'd0:    inc = (rem > half) || ((rem == half) && q[0]);
            3'd2:    inc = nx && neg;
            3'd3:    inc = nx && !neg;
            3'd4:    inc = (rem >= half);
            default: inc = 1'b0;
        endcase
        q = q + 64'(inc);
        if (q == 64'h100_0000) begin q = 64'h80_0000; p++; end
        return {neg, 8'(p + 127), q[22:0]};
    endfunction

    // Reference: binary32 to integer via exact scaling, rounding and saturation.
    function automatic logic [63:0] ref_f2i(input logic [31:0] f, input int w, input bit sg,
                                            input logic [2:0] r, output bit nv, output bit nx);
        logic [127:0] q, rem, half, lim_pos, lim_neg, mask, sig;
        bit neg, inc;
        int ee, sh, k;
        mask    = (w == 32) ? 128'hFFFF_FFFF : 128'hFFFF_FFFF_FFFF_FFFF;
        lim_pos = sg ? (mask >> 1) : mask;
        lim_neg = sg ? ((mask >> 1) + 128'd1) : 128'd0;
        neg = f[31]; nv = 1'b0; nx = 1'b0;
        if (f[30:23] == 8'hFF) begin
            nv = 1'b1;
            if ((f[22:0] != 23'd0) || !neg) return lim_pos[63:0];
            return lim_neg[63:0];
        end
        if (f[30:0] == 31'd0) return 64'd0;
        ee  = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
        sig = {104'd0, (f[30:23] != 8'd0), f[22:0]};
        sh  = ee - 150;
        if (sh >= 0) begin
            if (sh > 80) sh = 80;
            q = sig << sh; rem = 128'd0; half = 128'd1;
        end else begin
            k = -sh;
            if (k >= 25) begin
                q = 128'd0; rem = 128'd1; half = 128'd2;
            end else begin
                q = sig >> k; rem = sig & ((128'd1 << k) - 128'd1); half = 128'd1 << (k - 1);
            end
        end
        nx = (rem != 128'd0);
        case (r)
            3'd0:    inc = (rem > half) || ((rem == half) && q[0]);
            3'd2:    inc = nx && neg;
            3'd3:    inc = nx && !neg;
            3'd4:    inc = (rem >= half);
            default: inc = 1'b0;
        endcase
        q = q + 128'(inc);
        if (!neg) begin
            if (q > lim_pos) begin nv = 1'b1; nx = 1'b0; return lim_pos[63:0]; end
            return q[63:0];
        end
        if (q > lim_neg) begin nv = 1'b1; nx = 1'b0; return lim_neg[63:0]; end
        q = (-q) & mask;
        return q[63:0];
    endfunction

    function automatic int norm_cycles(input logic [63:0] v, input int w, input bit sg, input int step);
        logic [63:0] mask, m;
        int lz;
        mask = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        m    = (sg && v[w-1]) ? ((~v + 64'd1) & mask) : (v & mask);
        lz   = 0;
        if (m != 64'd0) begin
            for (int i = w - 1; i >= 0 && !m[i]; i--) lz++;
        end
        return lz / step + lz % step + 1;
    endfunction

    function automatic logic ovl(input bit w64);  return w64 ? b_out_valid : a_out_valid; endfunction
    function automatic logic rdy(input bit w64);  return w64 ? b_in_ready : a_in_ready;   endfunction
    function automatic logic [63:0] res(input bit w64); return w64 ? b_out : {32'd0, a_out}; endfunction
    function automatic logic fnv(input bit w64);  return w64 ? b_nv : a_nv; endfunction
    function automatic logic fnx(input bit w64);  return w64 ? b_nx : a_nx; endfunction

    task automatic drive(input bit w64, input bit vld, input bit opt, input bit sg,
                         input logic [2:0] r, input logic [63:0] v);
        if (w64) begin
            b_in_valid = vld; b_option = opt; b_sgn = sg; b_rm = r; b_in = v;
        end else begin
            a_in_valid = vld; a_option = opt; a_sgn = sg; a_rm = r; a_in = v[31:0];
        end
    endtask

    task automatic set_ordy(input bit w64, input bit val);
        if (w64) b_out_ready = val; else a_out_ready = val;
    endtask

    // One complete transaction: accept, latency, result, optional stall, handshake.
    task automatic op(input bit w64, input bit opt, input bit sg, input logic [2:0] r,
                      input logic [63:0] v, input int hold);
        logic [63:0] vv, e_out;
        bit e_nv, e_nx;
        int e_lat, n, w;
        w  = w64 ? 64 : 32;
        vv = w64 ? v : {32'd0, v[31:0]};
        if (opt) begin
            e_out = ref_f2i(vv[31:0], w, sg, r, e_nv, e_nx);
            e_lat = 1;
        end else begin
            e_out = {32'd0, ref_i2f(vv, w, sg, r, e_nx)};
            e_nv  = 1'b0;
            e_lat = norm_cycles(vv, w, sg, w64 ? 8 : 4) + 1;
        end
        drive(w64, 1'b1, opt, sg, r, vv);
        chk("in_ready_idle", 64'(rdy(w64)), 64'd1);
        @(posedge clk); #1;
        drive(w64, 1'b0, ~opt, ~sg, 3'($urandom_range(0, 7)), {$urandom, $urandom});
        chk("in_ready_busy", 64'(rdy(w64)), 64'd0);
        n = 0;
        while (!ovl(w64) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(e_lat));
        chk("out_valid", 64'(ovl(w64)), 64'd1);
        chk("out", res(w64), e_out);
        chk("NV", 64'(fnv(w64)), 64'(e_nv));
        chk("NX", 64'(fnx(w64)), 64'(e_nx));
        last_out = res(w64);
        for (int i = 0; i < hold; i++) begin
            drive(w64, 1'b1, $urandom_range(0, 1) == 1, 1'b1, 3'd0, {$urandom, $urandom});
            @(posedge clk); #1;
            chk("hold_out", res(w64), e_out);
            chk("hold_flags", {62'd0, fnv(w64), fnx(w64)}, {62'd0, e_nv, e_nx});
            chk("hold_valid", 64'(ovl(w64)), 64'd1);
            chk("hold_in_ready", 64'(rdy(w64)), 64'd0);
        end
        drive(w64, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        set_ordy(w64, 1'b1);
        @(posedge clk); #1;
        set_ordy(w64, 1'b0);
        chk("hs_out_valid", 64'(ovl(w64)), 64'd0);
        chk("hs_in_ready", 64'(rdy(w64)), 64'd1);
    endtask

    function automatic logic [31:0] rand_fp(input int w);
        logic [7:0] e;
        logic [22:0] fr;
        int sel;
        sel = $urandom_range(0, 11);
        if (sel == 0)      e = 8'hFF;
        else if (sel == 1) e = 8'h00;
        else if (sel == 2) e = 8'($urandom_range(0, 255));
        else               e = 8'($urandom_range(110, 127 + w + 1));
        fr = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, fr};
    endfunction

    initial begin
        bit w64, opt;
        logic [63:0] v;
        checks = 0; errors = 0; last_out = 64'd0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out", 64'(a_out), 64'd0);
        chk("rst_flags", {62'd0, a_nv, a_nx}, 64'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {62'd0, a_in_ready, b_in_ready}, 64'd3);

        // Directed plan cases (32-bit instance unless noted).
        op(1'b0, 1'b0, 1'b1, 3'd0, 64'd1, 0);
        chk("tp_one", last_out, 64'h3F80_0000);
        op(1'b0, 1'b0, 1'b0, 3'd0, 64'h7FFF_FFFF, 1);
        chk("tp_carry", last_out, 64'h4F00_0000);
        op(1'b0, 1'b0, 1'b0, 3'd0, 64'h0100_0001, 0);
        chk("tp_tie_rne", last_out, 64'h4B80_0000);
        op(1'b0, 1'b0, 1'b0, 3'd4, 64'h0100_0001, 0);
        chk("tp_tie_rmm", last_out, 64'h4B80_0001);
        op(1'b0, 1'b1, 1'b1, 3'd0, 64'hC020_0000, 0);
        chk("tp_m25_rne", last_out, 64'hFFFF_FFFE);
        op(1'b0, 1'b1, 1'b1, 3'd4, 64'hC020_0000, 0);
        chk("tp_m25_rmm", last_out, 64'hFFFF_FFFD);
        op(1'b0, 1'b1, 1'b1, 3'd3, 64'hC020_0000, 0);
        chk("tp_m25_rup", last_out, 64'hFFFF_FFFE);
        op(1'b0, 1'b1, 1'b1, 3'd2, 64'hC020_0000, 0);
        chk("tp_m25_rdn", last_out, 64'hFFFF_FFFD);
        op(1'b0, 1'b1, 1'b1, 3'd0, 64'h7FC0_0000, 0);
        chk("tp_nan_s", last_out, 64'h7FFF_FFFF);
        op(1'b0, 1'b1, 1'b0, 3'd0, 64'h7FC0_0000, 0);
        chk("tp_nan_u", last_out, 64'hFFFF_FFFF);
        op(1'b0, 1'b1, 1'b0, 3'd0, 64'hBF80_0000, 0);
        chk("tp_neg1_u", last_out, 64'd0);
        op(1'b0, 1'b1, 1'b0, 3'd1, 64'hBE99_999A, 0);
        chk("tp_negfrac_u", last_out, 64'd0);
        op(1'b1, 1'b0, 1'b1, 3'd0, 64'h8000_0000_0000_0000, 0);
        chk("tp64_i2f", last_out, 64'hDF00_0000);
        op(1'b1, 1'b1, 1'b0, 3'd0, 64'h5F80_0000, 0);
        chk("tp64_u_sat", last_out, 64'hFFFF_FFFF_FFFF_FFFF);
        op(1'b1, 1'b1, 1'b1, 3'd0, 64'h5F00_0000, 0);
        chk("tp64_s_sat", last_out, 64'h7FFF_FFFF_FFFF_FFFF);
        op(1'b0, 1'b1, 1'b1, 3'd0, 64'h4040_0000, 5);
        chk("tp_stall", last_out, 64'd3);

        // Reset in the middle of normalisation discards the operation.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 64'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_norm_valid", 64'(a_out_valid), 64'd0);
        chk("rst_norm_out", 64'(a_out), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        #1;
        chk("rst_norm_ready", 64'(a_in_ready), 64'd1);
        op(1'b0, 1'b0, 1'b1, 3'd0, 64'd1, 0);
        chk("rst_fresh", last_out, 64'h3F80_0000);

        // Reset while a result is waiting in DONE.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 64'h4040_0000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0);
        @(posedge clk); #1;
        chk("done_valid", 64'(a_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_done_valid", 64'(a_out_valid), 64'd0);
        chk("rst_done_out", 64'(a_out), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Randomized operations on both widths.
        for (int t = 0; t < 160; t++) begin
            w64 = (t % 3 == 2);
            opt = 1'($urandom_range(0, 1));
            if (opt) v = {32'd0, rand_fp(w64 ? 64 : 32)};
            else     v = {$urandom, $urandom} >> $urandom_range(0, 63);
            op(w64, opt, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), v,
               $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_int_converter_pipe.md
# fp_int_converter_pipe

Parametrised successor to the single-precision integer/float converter in the FPU datapath. It converts between `INT_W`-bit signed or unsigned integers and IEEE-754 binary32 in both directions. Normalisation is iterative, with a configurable shift stride per cycle. The block has valid/ready handshakes on both sides, so it can sit behind the FPU issue stage and stall on writeback backpressure.

## Interface
- `INT_W`, default 32: integer width; legal values 32, 64.
- `SHIFT_STEP`, default 4: maximum left-shift per normalisation cycle; power of two, 1 to 16.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `option`  in  1  0: integer to fp; 1: fp to integer.
- `integer_is_signed`  in  1  integer operand/result is two's complement.
- `rm`  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 behave as RTZ.
- `in`  in  INT_W  integer operand, or fp operand in `in[31:0]` (upper bits ignored).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out`  out  INT_W  integer result, or fp result in `out[31:0]` with upper bits zero.
- `NV`  out  1  invalid flag; qualified by `out_valid`.
- `NX`  out  1  inexact flag; qualified by `out_valid`.

## Operation
- **States:** IDLE, NORM, ROUND, CVT, DONE.
- **IDLE:** `in_ready=1`. On `in_valid`, capture all inputs.
  - `option=0`: go to NORM.
  - `option=1`: go to CVT.
  - Later input changes are ignored until the next accept.
- **Int to fp capture:**
  - sign = `integer_is_signed & in[INT_W-1]`.
  - mag = |in|.
  - exp = 127+INT_W-1 (9-bit internal).
- **NORM (int to fp):** evaluated on the registered value, one action per cycle.
  - If mag==0 or mag[INT_W-1]==1: go to ROUND.
  - Else if the top `SHIFT_STEP` bits are all zero: shift mag left by `SHIFT_STEP` and subtract `SHIFT_STEP` from exp.
  - Else: shift left by 1 and subtract 1 from exp.
- **ROUND:**
  - Mantissa = mag[INT_W-1:INT_W-24].
  - guard = mag[INT_W-25], round = mag[INT_W-26], sticky = OR of the remaining low bits.
  - NX = (g|r|s).
  - Increment rules:
    - RNE: g&(r|s|lsb).
    - RTZ: never.
    - RDN: NX&sign.
    - RUP: NX&~sign.
    - RMM: g.
  - Mantissa carry-out: mantissa becomes 1.0, exp+1.
  - Zero input gives +0, NX=0. NV is always 0 in this direction.
  - Result is registered; go to DONE.
- **CVT (fp to int):** single cycle, registered; go to DONE.
  - NaN (exp=FF, frac≠0) or +inf:
    - signed: 2^(INT_W-1)-1.
    - unsigned: all ones.
    - NV=1.
  - −inf:
    - signed: −2^(INT_W-1).
    - unsigned: 0.
    - NV=1.
  - ±0 gives 0 with no flags. Subnormals are treated as |x|<1 and rounded normally.
  - Finite values: shift the significand into integer plus g/r/s fields and round per `rm` as in ROUND.
  - Overflow of the rounded magnitude saturates and sets NV=1 with NX=0:
    - signed: magnitude > 2^(INT_W-1)-1 for positive, > 2^(INT_W-1) for negative.
    - unsigned: magnitude > 2^INT_W-1.
  - Negative input with unsigned result:
    - If it rounds to 0: result 0 with NX per rounding.
    - Otherwise: result 0 with NV=1, NX=0.
- **DONE:** `out_valid=1`; `out`, `NV`, `NX` are stable. On `out_ready`, go to IDLE.

## Timing
- **Reset:** while `rst_n` is low, and immediately on assertion (including mid-NORM, ROUND or DONE):
  - state IDLE.
  - `in_ready=1` once reset is released.
  - `out_valid=0`, `out=0`, `NV=0`, `NX=0`.
  - In-flight operation is discarded.
- **Accept:** occurs at edge E0 when `in_valid&in_ready`.
- **Fp to int latency:** `out_valid` rises after E1 (one cycle).
- **Int to fp latency:** lz = leading zeros of mag (lz=0 for mag==0).
  - NORM cycles = floor(lz/SHIFT_STEP) + (lz mod SHIFT_STEP) + 1.
  - `out_valid` rises NORM cycles + 1 edges after E0.
- **Backpressure:** the result holds indefinitely while `out_ready=0`. `in_ready` stays low until the DONE-to-IDLE edge.
- **No overlap:** the earliest next accept is the edge after the handshake edge.
- **Simultaneous events:** `in_valid` asserted in the DONE cycle is ignored; the request must persist into IDLE.

## Test plan
- **Int to fp, small value:** INT_W=32, STEP=4, signed, `in`=1, RNE -> `out`=0x3F800000, NX=0, NV=0; exactly 11 NORM cycles; `out_valid` 12 edges after accept.
- **Int to fp, round carry and ties:**
  - unsigned 0x7FFFFFFF, RNE -> 0x4F000000, NX=1.
  - 0x01000001, RNE -> 0x4B800000, NX=1.
  - 0x01000001, RMM -> 0x4B800001, NX=1.
- **Fp to int, signed -2.5:**
  - 0xC0200000, RNE -> 0xFFFFFFFE, NX=1.
  - RMM -> 0xFFFFFFFD.
  - RUP -> 0xFFFFFFFE.
  - RDN -> 0xFFFFFFFD.
  - Latency 1 cycle in every case.
- **Fp to int, specials:**
  - 0x7FC00000 signed -> 0x7FFFFFFF, NV=1.
  - 0x7FC00000 unsigned -> 0xFFFFFFFF, NV=1.
  - 0xBF800000 unsigned -> 0, NV=1.
  - 0xBE99999A unsigned RTZ -> 0, NX=1, NV=0.
- **INT_W=64, both directions:**
  - 0x8000000000000000 signed -> 0xDF000000, NX=0.
  - 0x5F800000 unsigned -> all ones, NV=1.
  - 0x5F000000 signed -> 0x7FFFFFFFFFFFFFFF, NV=1.
- **Handshake/reset:**
  - Hold `out_ready`=0 for 5 cycles -> `out` and flags stable, `in_ready`=0.
  - Drop `rst_n` mid-NORM -> `out_valid`=0 immediately; after release, a fresh `in`=1 conversion yields 0x3F800000.
